// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameters for the run controller and its stall detector.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_t;

    localparam int RST_CYCLES_DEF   = 2;
    localparam int MAX_CYCLES_DEF   = 50;
    localparam int STALL_CYCLES_DEF = 8;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pc_stall_detector.sv
// Flags a core whose PC has not moved for STALL_CYCLES consecutive RUN cycles.
// Instantiated by run_ctrl only when RUN_CTRL_STALL_DETECT_EN is defined.
module pc_stall_detector
    import run_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic            ref_clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            enable,
    input  logic [PC_W-1:0] pc,
    output logic            stall
);

    localparam int             SW         = cnt_w(STALL_CYCLES);
    localparam logic [SW-1:0]  STALL_LAST = SW'(STALL_CYCLES - 1);

    logic [PC_W-1:0] pc_prev;
    logic            prev_valid;
    logic [SW-1:0]   same_cnt;
    logic            same;

    // prev_valid keeps the first RUN cycle from comparing against a stale PC.
    assign same  = prev_valid && (pc == pc_prev);
    assign stall = enable && same && (same_cnt == STALL_LAST);

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            pc_prev    <= '0;
            prev_valid <= 1'b0;
            same_cnt   <= '0;
        end else if (clear) begin
            prev_valid <= 1'b0;
            same_cnt   <= '0;
        end else if (enable) begin
            pc_prev    <= pc;
            prev_valid <= 1'b1;
            if (!same) begin
                same_cnt <= '0;
            end else if (same_cnt != STALL_LAST) begin
                same_cnt <= same_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: start pulse -> stretched core reset -> counted run ending in DONE or TIMEOUT.
// Optional PC stall detection is compiled in with RUN_CTRL_STALL_DETECT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | out of reset, core held in reset, waiting for start
// ST_HOLD    | core reset stretched for RST_CYCLES cycles
// ST_RUN     | core running, cycle_count advancing
// ST_DONE    | halt or stall seen, core frozen, count held
// ST_TIMEOUT | cycle budget exhausted, core frozen, count held
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int MAX_CYCLES   = MAX_CYCLES_DEF,
    parameter int CNT_W        = 32,
    parameter int PC_W         = 32,
    parameter int STALL_CYCLES = STALL_CYCLES_DEF
) (
    input  logic             ref_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic [PC_W-1:0]  pc,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic             stalled,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int               HW        = cnt_w(RST_CYCLES);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_CYCLES - 1);

    run_state_t       state, state_nxt;
    logic [HW-1:0]    hold_cnt, hold_cnt_nxt;
    logic [CNT_W-1:0] cycle_count_nxt;
    logic             stalled_nxt;
    logic             stall_hit;

`ifdef RUN_CTRL_STALL_DETECT_EN
    pc_stall_detector #(
        .PC_W         (PC_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall (
        .ref_clk (ref_clk),
        .reset   (reset),
        .clear   (state != ST_RUN),
        .enable  (state == ST_RUN),
        .pc      (pc),
        .stall   (stall_hit)
    );
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign stall_hit = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        hold_cnt_nxt    = hold_cnt;
        cycle_count_nxt = cycle_count;
        stalled_nxt     = stalled;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt       = ST_HOLD;
                    hold_cnt_nxt    = '0;
                    cycle_count_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt       = ST_RUN;
                    cycle_count_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end
            ST_RUN: begin
                // The exit cycle is counted too, so a halt in cycle k reports k.
                cycle_count_nxt = cycle_count + CNT_W'(1);
                if (halt) begin
                    state_nxt = ST_DONE;
                end else if (stall_hit) begin
                    state_nxt   = ST_DONE;
                    stalled_nxt = 1'b1;
                end else if (cycle_count == CNT_LAST) begin
                    state_nxt = ST_TIMEOUT;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start) begin
                    state_nxt       = ST_HOLD;
                    hold_cnt_nxt    = '0;
                    cycle_count_nxt = '0;
                    stalled_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are flops loaded from the next state so nothing is decoded after the register.
    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            hold_cnt    <= '0;
            cycle_count <= '0;
            stalled     <= 1'b0;
            core_reset  <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            cycle_count <= cycle_count_nxt;
            stalled     <= stalled_nxt;
            core_reset  <= (state_nxt != ST_RUN);
            running     <= (state_nxt == ST_RUN);
            done        <= (state_nxt == ST_DONE);
            timeout     <= (state_nxt == ST_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with default parameters; RUN_CTRL_STALL_DETECT_EN selects stall expectations.
module tb_run_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 32;

    typedef struct {
        bit          done;
        bit          timeout;
        bit          stalled;
        int unsigned count;
    } exp_t;

    logic             ref_clk = 1'b0;
    logic             reset;
    logic             start;
    logic             halt;
    logic [PC_W-1:0]  pc;
    logic             core_reset;
    logic             running;
    logic             done;
    logic             timeout;
    logic             stalled;
    logic [CNT_W-1:0] cycle_count;

    int   tests  = 0;
    int   failed = 0;
    exp_t exp_q[$];

    run_ctrl #(
        .RST_CYCLES   (2),
        .MAX_CYCLES   (50),
        .CNT_W        (CNT_W),
        .PC_W         (PC_W),
        .STALL_CYCLES (8)
    ) dut (
        .ref_clk     (ref_clk),
        .reset       (reset),
        .start       (start),
        .halt        (halt),
        .pc          (pc),
        .core_reset  (core_reset),
        .running     (running),
        .done        (done),
        .timeout     (timeout),
        .stalled     (stalled),
        .cycle_count (cycle_count)
    );

    always #5 ref_clk = ~ref_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse start for one sampling edge; returns at the negedge of the first cycle after that edge.
    task automatic pulse_start();
        halt  = 1'b0;
        start = 1'b1;
        @(negedge ref_clk);
        start = 1'b0;
    endtask

    // Drives halt/pc per RUN cycle (counted by the bench) until DONE/TIMEOUT or RUN cycle stop_at.
    task automatic do_run(input int halt_at, input int freeze_at, input int stop_at,
                          input int start_lo, input int start_hi, input string name);
        int k     = 0;
        int guard = 0;
        forever begin
            halt  = 1'b0;
            start = 1'b0;
            if (running) begin
                k++;
                tests++;
                if (cycle_count !== CNT_W'(k - 1)) begin
                    failed++;
                    $display("FAIL %s run_count k=%0d: got %0d expected %0d", name, k, cycle_count, k - 1);
                end
                if (stop_at != 0 && k == stop_at) break;
                halt  = (k == halt_at);
                start = (k >= start_lo && k <= start_hi);
                pc    = (freeze_at != 0 && k >= freeze_at) ? 32'h0000_0100 : 32'h0000_1000 + 32'(k * 4);
            end
            if (done || timeout || guard >= 300) break;
            @(negedge ref_clk);
            guard++;
        end
        halt  = 1'b0;
        start = 1'b0;
        tests++;
        if (guard >= 300) begin
            failed++;
            $display("FAIL %s wait_end: no DONE/TIMEOUT within 300 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        halt  = 1'b0;
        pc    = '0;
        repeat (3) @(negedge ref_clk);
        tests++;
        if ({core_reset, running, done, timeout, stalled} !== 5'b10000 || cycle_count !== 0) begin
            failed++;
            $display("FAIL reset_values: got cr/run/done/to/st=%b count=%0d expected 10000 count=0",
                     {core_reset, running, done, timeout, stalled}, cycle_count);
        end
        #2 reset = 1'b1;
        repeat (10) @(negedge ref_clk);
        tests++;
        if ({core_reset, running, done, timeout, stalled} !== 5'b10000 || cycle_count !== 0) begin
            failed++;
            $display("FAIL idle_no_start: got cr/run/done/to/st=%b count=%0d expected 10000 count=0",
                     {core_reset, running, done, timeout, stalled}, cycle_count);
        end
    endtask

    task automatic test_start_halt();
        exp_t e;
        pulse_start();
        for (int c = 1; c <= 2; c++) begin
            tests++;
            if (core_reset !== 1'b1 || running !== 1'b0) begin
                failed++;
                $display("FAIL hold_cycle%0d: got core_reset=%b running=%b expected 1 0", c, core_reset, running);
            end
            @(negedge ref_clk);
        end
        tests++;
        if (core_reset !== 1'b0 || running !== 1'b1) begin
            failed++;
            $display("FAIL run_entry: got core_reset=%b running=%b expected 0 1", core_reset, running);
        end
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, stalled: 1'b0, count: 10});
        do_run(10, 0, 0, 0, 0, "halt10");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled, core_reset} !== {e.done, e.timeout, e.stalled, 1'b1} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL halt10_end: got d/t/s/cr=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled, core_reset}, cycle_count, {e.done, e.timeout, e.stalled, 1'b1}, e.count);
        end
        repeat (4) @(negedge ref_clk);
        tests++;
        if (done !== 1'b1 || running !== 1'b0 || cycle_count !== 10) begin
            failed++;
            $display("FAIL done_sticky: got done=%b running=%b count=%0d expected 1 0 10", done, running, cycle_count);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        pulse_start();
        exp_q.push_back('{done: 1'b0, timeout: 1'b1, stalled: 1'b0, count: 50});
        do_run(0, 0, 0, 0, 0, "timeout");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled, core_reset} !== {e.done, e.timeout, e.stalled, 1'b1} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL timeout_end: got d/t/s/cr=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled, core_reset}, cycle_count, {e.done, e.timeout, e.stalled, 1'b1}, e.count);
        end
    endtask

    task automatic test_halt_last();
        exp_t e;
        pulse_start();
        tests++;
        if (timeout !== 1'b0 || cycle_count !== 0) begin
            failed++;
            $display("FAIL restart_from_timeout: got timeout=%b count=%0d expected 0 0", timeout, cycle_count);
        end
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, stalled: 1'b0, count: 50});
        do_run(50, 0, 0, 0, 0, "halt_last");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled} !== {e.done, e.timeout, e.stalled} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL halt_last_end: got d/t/s=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled}, cycle_count, {e.done, e.timeout, e.stalled}, e.count);
        end
    endtask

    task automatic test_reset_mid_run();
        exp_t e;
        pulse_start();
        do_run(0, 0, 21, 0, 0, "pre_reset");
        tests++;
        if (running !== 1'b1 || cycle_count !== 20) begin
            failed++;
            $display("FAIL mid_run_point: got running=%b count=%0d expected 1 20", running, cycle_count);
        end
        #1 reset = 1'b0;
        #1;
        tests++;
        if ({core_reset, running, done, timeout, stalled} !== 5'b10000 || cycle_count !== 0) begin
            failed++;
            $display("FAIL async_reset: got cr/run/done/to/st=%b count=%0d expected 10000 count=0",
                     {core_reset, running, done, timeout, stalled}, cycle_count);
        end
        @(negedge ref_clk);
        reset = 1'b1;
        @(negedge ref_clk);
        tests++;
        if (core_reset !== 1'b1 || running !== 1'b0) begin
            failed++;
            $display("FAIL no_resume: got core_reset=%b running=%b expected 1 0", core_reset, running);
        end
        pulse_start();
        for (int c = 1; c <= 2; c++) begin
            tests++;
            if (core_reset !== 1'b1 || running !== 1'b0) begin
                failed++;
                $display("FAIL rehold_cycle%0d: got core_reset=%b running=%b expected 1 0", c, core_reset, running);
            end
            @(negedge ref_clk);
        end
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, stalled: 1'b0, count: 7});
        do_run(7, 0, 0, 0, 0, "after_reset");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled} !== {e.done, e.timeout, e.stalled} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL after_reset_end: got d/t/s=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled}, cycle_count, {e.done, e.timeout, e.stalled}, e.count);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        pulse_start();
`ifdef RUN_CTRL_STALL_DETECT_EN
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, stalled: 1'b1, count: 13});
`else
        exp_q.push_back('{done: 1'b0, timeout: 1'b1, stalled: 1'b0, count: 50});
`endif
        do_run(0, 5, 0, 0, 0, "stall");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled} !== {e.done, e.timeout, e.stalled} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL stall_end: got d/t/s=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled}, cycle_count, {e.done, e.timeout, e.stalled}, e.count);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        pulse_start();
        tests++;
        if ({core_reset, running, done, timeout, stalled} !== 5'b10000 || cycle_count !== 0) begin
            failed++;
            $display("FAIL restart_hold: got cr/run/done/to/st=%b count=%0d expected 10000 count=0",
                     {core_reset, running, done, timeout, stalled}, cycle_count);
        end
        @(negedge ref_clk);
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, stalled: 1'b0, count: 12});
        do_run(12, 0, 0, 3, 6, "start_in_run");
        e = exp_q.pop_front();
        tests++;
        if ({done, timeout, stalled} !== {e.done, e.timeout, e.stalled} || cycle_count !== e.count) begin
            failed++;
            $display("FAIL start_in_run_end: got d/t/s=%b count=%0d expected %b count=%0d",
                     {done, timeout, stalled}, cycle_count, {e.done, e.timeout, e.stalled}, e.count);
        end
    endtask

    initial begin
        test_reset();
        test_start_halt();
        test_timeout();
        test_halt_last();
        test_reset_mid_run();
        test_stall();
        test_back_to_back();
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Synthesisable run controller between the board/bench clock-reset source and the multi-cycle `processor`. It turns a single `start` pulse into a stretched, clean active-high core reset. It then runs the core while counting cycles, and ends the run on a halt indication, a cycle-budget timeout or, optionally, a stuck-PC stall. It replaces fixed-delay reset/finish sequencing with a parametrised, observable, restartable run sequence.

## Interface
- RST_CYCLES, 2: cycles `core_reset` is held high after `start` (≥1)
- MAX_CYCLES, 50: RUN-cycle budget before timeout (≥1)
- CNT_W, 32: width of `cycle_count` (must hold MAX_CYCLES)
- PC_W, 32: width of `pc`
- STALL_CYCLES, 8: consecutive unchanged-PC cycles that flag a stall (≥1)

- ref_clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; low forces all state to reset values
- start  in  1  level sampled each cycle; honoured only in IDLE, DONE, TIMEOUT
- halt  in  1  core retired a halt instruction this cycle
- pc  in  PC_W  core program counter
- core_reset  out  1  active-high reset to `processor`
- running  out  1  high in RUN
- done  out  1  high in DONE (halt or stall end)
- timeout  out  1  high in TIMEOUT
- stalled  out  1  DONE was entered via stall detection
- cycle_count  out  CNT_W  RUN cycles elapsed in current/last run

## Operation
- States (`run_state_t`): IDLE, HOLD, RUN, DONE, TIMEOUT.
- Reset values: state IDLE, core_reset=1, running=0, done=0, timeout=0, stalled=0, cycle_count=0.
- IDLE: core_reset=1; start → HOLD, hold counter=0.
- HOLD: core_reset=1; counts RST_CYCLES cycles, then → RUN with cycle_count=0; start ignored.
- RUN: core_reset=0, running=1; cycle_count +1 every cycle, including the exit cycle. Priority per cycle: halt → DONE; else stall → DONE with stalled=1; else cycle_count==MAX_CYCLES-1 → TIMEOUT; start ignored.
- DONE/TIMEOUT: sticky, core_reset=1 to freeze the core, cycle_count held; start → HOLD, clears cycle_count, stalled, done, timeout.
- cycle_count never exceeds MAX_CYCLES; no wrap.
- reset low in any state, including mid-HOLD or mid-RUN: immediate return to reset values; no partial run is resumed.

## Timing
- All outputs registered; decoded from state/counters with no combinational path from inputs.
- start high at edge t → HOLD from t+1; core_reset high through t+RST_CYCLES; RUN (core_reset=0) from t+1+RST_CYCLES.
- halt high in the k-th RUN cycle → done=1 next cycle, cycle_count=k.
- No halt → timeout=1 after exactly MAX_CYCLES RUN cycles, cycle_count=MAX_CYCLES.
- halt in the final budget cycle → DONE, not TIMEOUT.
- reset deassertion is taken asynchronously; the first active edge after release samples start normally.

## Configuration
- RUN_CTRL_STALL_DETECT_EN defined: compare `pc` with the previous RUN cycle's registered value, with comparison disabled in the first RUN cycle. Count consecutive equal cycles; reaching STALL_CYCLES ends the run through DONE with stalled=1.
- Not defined: no PC register or stall counter; `pc` unused; stalled tied 0; runs end only by halt or timeout.

## Structure
- Package `run_ctrl_pkg`: `run_state_t` enum and default parameter constants RST_CYCLES_DEF, MAX_CYCLES_DEF, STALL_CYCLES_DEF.
- Sub-module `pc_stall_detector` holds the PC register and stall counter, with inputs `clear` and `enable`. It is instantiated only under RUN_CTRL_STALL_DETECT_EN.

## Test plan
- reset low, then high, no start → core_reset=1, all other outputs 0, state IDLE indefinitely.
- Defaults, start pulse at t → core_reset high through t+2, low from t+3; halt in 10th RUN cycle → done=1, cycle_count=10, core_reset=1.
- MAX_CYCLES=50, halt never → timeout=1, cycle_count=50; halt in 50th cycle instead → done=1, timeout=0.
- RUN with cycle_count=20, reset pulsed low → reset values immediately; next start yields a full RST_CYCLES hold and count from 0.
- Macro defined, STALL_CYCLES=8, pc frozen from RUN cycle 5 → done=1, stalled=1 at cycle 13. Macro undefined → same stimulus reaches timeout.
- After DONE, start again → done cleared, HOLD re-entered, cycle_count restarts at 0; start during RUN has no effect.
